// File: rtl/trainer.sv
// trainer: sequences one activation unit through forward and optional
// backward (training) passes, one handshake per state.
//
// state | meaning
// IDLE  | waiting for an upstream sample (inp_rdy)
// ARG   | presenting the latched argument to the unit (arg_stb)
// RES   | accepting the unit's result (res_rdy)
// OUT   | presenting the result downstream (out_stb)
// TGT   | accepting the training target (tgt_rdy)
// ERR   | presenting target - result to the unit (err_stb)
// FBK   | accepting the unit's feedback (fbk_rdy)
// DLT   | presenting the feedback upstream (dlt_stb)
module trainer #(
  parameter int ARGW = 16,
  parameter int RESW = 8,
  parameter int ERRW = 16,
  parameter int FBKW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            train,
  input  logic [ARGW-1:0] inp_dat,
  input  logic            inp_stb,
  output logic            inp_rdy,
  input  logic [RESW-1:0] tgt_dat,
  input  logic            tgt_stb,
  output logic            tgt_rdy,
  output logic [ARGW-1:0] arg_dat,
  output logic            arg_stb,
  input  logic            arg_rdy,
  input  logic [RESW-1:0] res_dat,
  input  logic            res_stb,
  output logic            res_rdy,
  output logic            en,
  output logic [ERRW-1:0] err_dat,
  output logic            err_stb,
  input  logic            err_rdy,
  input  logic [FBKW-1:0] fbk_dat,
  input  logic            fbk_stb,
  output logic            fbk_rdy,
  output logic [RESW-1:0] out_dat,
  output logic            out_stb,
  input  logic            out_rdy,
  output logic [FBKW-1:0] dlt_dat,
  output logic            dlt_stb,
  input  logic            dlt_rdy
);

  typedef enum logic [2:0] {IDLE, ARG, RES, OUT, TGT, ERR, FBK, DLT} state_t;

  state_t state, state_nxt;

  logic inp_x, arg_x, res_x, out_x, tgt_x, err_x, fbk_x, dlt_x;
  logic inp_rdy_nxt, arg_stb_nxt, res_rdy_nxt, out_stb_nxt;
  logic tgt_rdy_nxt, err_stb_nxt, fbk_rdy_nxt, dlt_stb_nxt;

  // The result latch is out_dat itself; the error is formed as the target is
  // accepted, in RESW+1 bits so the full -(2^RESW-1)..+(2^RESW-1) range fits.
  logic signed [RESW:0]   err_diff;
  logic        [ERRW-1:0] err_calc;

  assign inp_x = inp_stb & inp_rdy;
  assign arg_x = arg_stb & arg_rdy;
  assign res_x = res_stb & res_rdy;
  assign out_x = out_stb & out_rdy;
  assign tgt_x = tgt_stb & tgt_rdy;
  assign err_x = err_stb & err_rdy;
  assign fbk_x = fbk_stb & fbk_rdy;
  assign dlt_x = dlt_stb & dlt_rdy;

  assign err_diff = $signed({1'b0, tgt_dat}) - $signed({1'b0, out_dat});
  assign err_calc = ERRW'(err_diff);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: each state leaves on its own channel's transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inp_x) state_nxt = ARG;
      ARG:     if (arg_x) state_nxt = RES;
      RES:     if (res_x) state_nxt = OUT;
      OUT:     if (out_x) state_nxt = en ? TGT : IDLE;
      TGT:     if (tgt_x) state_nxt = ERR;
      ERR:     if (err_x) state_nxt = FBK;
      FBK:     if (fbk_x) state_nxt = DLT;
      DLT:     if (dlt_x) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with entry
  always_comb begin
    inp_rdy_nxt = (state_nxt == IDLE);
    arg_stb_nxt = (state_nxt == ARG);
    res_rdy_nxt = (state_nxt == RES);
    out_stb_nxt = (state_nxt == OUT);
    tgt_rdy_nxt = (state_nxt == TGT);
    err_stb_nxt = (state_nxt == ERR);
    fbk_rdy_nxt = (state_nxt == FBK);
    dlt_stb_nxt = (state_nxt == DLT);
  end

  // Registered handshake outputs; reset drops them asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inp_rdy <= 1'b0;
      arg_stb <= 1'b0;
      res_rdy <= 1'b0;
      out_stb <= 1'b0;
      tgt_rdy <= 1'b0;
      err_stb <= 1'b0;
      fbk_rdy <= 1'b0;
      dlt_stb <= 1'b0;
    end else begin
      inp_rdy <= inp_rdy_nxt;
      arg_stb <= arg_stb_nxt;
      res_rdy <= res_rdy_nxt;
      out_stb <= out_stb_nxt;
      tgt_rdy <= tgt_rdy_nxt;
      err_stb <= err_stb_nxt;
      fbk_rdy <= fbk_rdy_nxt;
      dlt_stb <= dlt_stb_nxt;
    end
  end

  // Data latches double as the registered data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arg_dat <= '0;
      en      <= 1'b0;
      out_dat <= '0;
      err_dat <= '0;
      dlt_dat <= '0;
    end else begin
      if (inp_x) begin
        arg_dat <= inp_dat;
        en      <= train;
      end
      if (res_x) out_dat <= res_dat;
      if (tgt_x) err_dat <= err_calc;
      if (fbk_x) dlt_dat <= fbk_dat;
    end
  end

endmodule

// File: tb/tb_trainer.sv
// tb_trainer: directed samples with a scoreboard; the stimulus pushes the
// expected channel contents and a negedge monitor pops them on transfers.
module tb_trainer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        train = 1'b0;
  logic [15:0] inp_dat = '0;
  logic        inp_stb = 1'b0;
  logic        inp_rdy;
  logic [7:0]  tgt_dat = '0;
  logic        tgt_stb = 1'b1;
  logic        tgt_rdy;
  logic [15:0] arg_dat;
  logic        arg_stb;
  logic        arg_rdy = 1'b1;
  logic [7:0]  res_dat = '0;
  logic        res_stb = 1'b1;
  logic        res_rdy;
  logic        en;
  logic [15:0] err_dat;
  logic        err_stb;
  logic        err_rdy = 1'b1;
  logic [15:0] fbk_dat = '0;
  logic        fbk_stb = 1'b1;
  logic        fbk_rdy;
  logic [7:0]  out_dat;
  logic        out_stb;
  logic        out_rdy = 1'b1;
  logic [15:0] dlt_dat;
  logic        dlt_stb;
  logic        dlt_rdy = 1'b1;

  int total = 0;
  int bad = 0;

  logic [16:0] arg_q[$];
  logic [7:0]  out_q[$];
  logic [15:0] err_q[$];
  logic [15:0] dlt_q[$];

  typedef struct {
    bit          train;
    logic [15:0] inp;
    logic [7:0]  res;
    logic [7:0]  tgt;
    logic [15:0] err;
    logic [15:0] fbk;
    int          out_stall;
    int          dlt_stall;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  trainer dut (
    .clk(clk), .rst_n(rst_n), .train(train),
    .inp_dat(inp_dat), .inp_stb(inp_stb), .inp_rdy(inp_rdy),
    .tgt_dat(tgt_dat), .tgt_stb(tgt_stb), .tgt_rdy(tgt_rdy),
    .arg_dat(arg_dat), .arg_stb(arg_stb), .arg_rdy(arg_rdy),
    .res_dat(res_dat), .res_stb(res_stb), .res_rdy(res_rdy),
    .en(en),
    .err_dat(err_dat), .err_stb(err_stb), .err_rdy(err_rdy),
    .fbk_dat(fbk_dat), .fbk_stb(fbk_stb), .fbk_rdy(fbk_rdy),
    .out_dat(out_dat), .out_stb(out_stb), .out_rdy(out_rdy),
    .dlt_dat(dlt_dat), .dlt_stb(dlt_stb), .dlt_rdy(dlt_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobed value must match the queue head (also proves it
  // holds stable under backpressure); a transfer pops, so duplicates underflow.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arg_stb) begin
        chk("arg_pending", arg_q.size() > 0, 1);
        if (arg_q.size() > 0) begin
          chk("arg_dat", arg_dat, arg_q[0][15:0]);
          chk("en_arg", en, arg_q[0][16]);
          if (arg_rdy) void'(arg_q.pop_front());
        end
      end
      if (out_stb) begin
        chk("out_pending", out_q.size() > 0, 1);
        if (out_q.size() > 0) begin
          chk("out_dat", out_dat, out_q[0]);
          if (out_rdy) void'(out_q.pop_front());
        end
      end
      if (err_stb) begin
        chk("err_pending", err_q.size() > 0, 1);
        chk("en_err", en, 1);
        if (err_q.size() > 0) begin
          chk("err_dat", err_dat, err_q[0]);
          if (err_rdy) void'(err_q.pop_front());
        end
      end
      if (dlt_stb) begin
        chk("dlt_pending", dlt_q.size() > 0, 1);
        chk("en_dlt", en, 1);
        if (dlt_q.size() > 0) begin
          chk("dlt_dat", dlt_dat, dlt_q[0]);
          if (dlt_rdy) void'(dlt_q.pop_front());
        end
      end
    end
  end

  // One full sample; latency counts cycles from acceptance to inp_rdy again.
  // train is flipped after acceptance to show it is ignored outside IDLE.
  task automatic run(vec_t v);
    int cnt = 0;
    int ow = 0;
    int dw = 0;
    int cyc = 0;
    bit acc = 0;
    bit done = 0;
    bit take = 0;
    inp_dat = v.inp;
    train   = v.train;
    res_dat = v.res;
    tgt_dat = v.tgt;
    fbk_dat = v.fbk;
    out_rdy = (v.out_stall == 0);
    dlt_rdy = (v.dlt_stall == 0);
    arg_q.push_back({v.train, v.inp});
    out_q.push_back(v.res);
    if (v.train) begin
      err_q.push_back(v.err);
      dlt_q.push_back(v.fbk);
    end
    inp_stb = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        cnt++;
        if (inp_rdy) done = 1;
      end
      take = !acc && inp_stb && inp_rdy;
      if (out_stb && !out_rdy) ow++;
      if (dlt_stb && !dlt_rdy) dw++;
      @(posedge clk);
      #1;
      if (take) begin
        acc = 1;
        inp_stb = 1'b0;
        train = ~v.train;
      end
      if (ow >= v.out_stall) out_rdy = 1'b1;
      if (dw >= v.dlt_stall) dlt_rdy = 1'b1;
    end
    chk("sample_done", done, 1);
    chk("latency", cnt, v.lat);
    chk("drain", arg_q.size() + out_q.size() + err_q.size() + dlt_q.size(), 0);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{1'b0, 16'h0000, 8'hff, 8'h00, 16'h0000, 16'h0000, 0, 0, 4};
    vecs[1] = '{1'b1, 16'hffff, 8'h00, 8'hff, 16'h00ff, 16'hffff, 0, 0, 8};
    vecs[2] = '{1'b1, 16'h1234, 8'hff, 8'h00, 16'hff01, 16'h8000, 0, 0, 8};
    vecs[3] = '{1'b1, 16'h8000, 8'h80, 8'h80, 16'h0000, 16'h0001, 0, 0, 8};
    vecs[4] = '{1'b1, 16'h0042, 8'h10, 8'h30, 16'h0020, 16'h5a5a, 5, 3, 16};
    vecs[5] = '{1'b0, 16'h7fff, 8'h3c, 8'h11, 16'h0000, 16'h0000, 0, 0, 4};

    #12;
    chk("rst_flags", {inp_rdy, tgt_rdy, arg_stb, res_rdy, en, err_stb, fbk_rdy, out_stb, dlt_stb}, 0);
    chk("rst_dat", {arg_dat, out_dat, err_dat, dlt_dat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rdy_before_edge", inp_rdy, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_release", inp_rdy, 1);

    foreach (vecs[i]) run(vecs[i]);

    // Reset while stalled in ERR, then a clean forward sample
    err_rdy = 1'b0;
    inp_dat = 16'h1234;
    train   = 1'b1;
    res_dat = 8'h05;
    tgt_dat = 8'h07;
    arg_q.push_back({1'b1, 16'h1234});
    out_q.push_back(8'h05);
    err_q.push_back(16'h0002);
    inp_stb = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (inp_stb && inp_rdy) begin
        @(posedge clk);
        #1;
        inp_stb = 1'b0;
      end else if (err_stb) begin
        seen = 1;
      end
    end
    chk("err_reached", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {inp_rdy, tgt_rdy, arg_stb, res_rdy, en, err_stb, fbk_rdy, out_stb, dlt_stb}, 0);
    chk("abort_dat", {arg_dat, out_dat, err_dat, dlt_dat}, 0);
    chk("abort_fwd_drained", arg_q.size() + out_q.size(), 0);
    err_q.delete();
    dlt_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    err_rdy = 1'b1;
    run(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trainer.md
# trainer

Sequencer that drives one activation unit (e.g. `heaviside`) through its forward/backward protocol. It is the initiator on the unit's `arg`/`err` channels and the receiver on its `res`/`fbk` channels. For each upstream sample it issues the argument, collects and forwards the result, and optionally runs a training pass: it computes error = target − result, sends it to the unit, and forwards the returned feedback upstream. It sits between the layer datapath and one activation unit.

## Interface

- `ARGW`, 16: argument width (signed)
- `RESW`, 8: result/target width (unsigned)
- `ERRW`, 16: error width (signed); must be ≥ RESW+1
- `FBKW`, 16: feedback width (signed)

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `train` in 1: training mode, sampled on `inp` acceptance
- `inp_dat` in ARGW, `inp_stb` in 1, `inp_rdy` out 1: upstream sample
- `tgt_dat` in RESW, `tgt_stb` in 1, `tgt_rdy` out 1: training target
- `arg_dat` out ARGW, `arg_stb` out 1, `arg_rdy` in 1: argument to unit
- `res_dat` in RESW, `res_stb` in 1, `res_rdy` out 1: result from unit
- `en` out 1: unit backward enable
- `err_dat` out ERRW, `err_stb` out 1, `err_rdy` in 1: error to unit
- `fbk_dat` in FBKW, `fbk_stb` in 1, `fbk_rdy` out 1: feedback from unit
- `out_dat` out RESW, `out_stb` out 1, `out_rdy` in 1: result downstream
- `dlt_dat` out FBKW, `dlt_stb` out 1, `dlt_rdy` in 1: feedback upstream

## Operation

- Handshake on every channel: a transfer occurs at a posedge with `stb && rdy`. A master holds `stb` and `dat` stable until the transfer. A slave asserts `rdy` only in its owning state.
- All outputs are registered.
- States: IDLE, ARG, RES, OUT, TGT, ERR, FBK, DLT.
  - IDLE: `inp_rdy`=1. On transfer, latch `inp_dat` and `train` → ARG.
  - ARG: `arg_stb`=1, `arg_dat`=latched input. On transfer → RES.
  - RES: `res_rdy`=1. Latch `res_dat` → OUT.
  - OUT: `out_stb`=1, `out_dat`=latched result. On transfer → TGT if train latched, else IDLE.
  - TGT: `tgt_rdy`=1. Latch target → ERR.
  - ERR: `err_stb`=1, `err_dat` = zero-extended target − zero-extended result, range −(2^RESW−1)..+(2^RESW−1), sign-extended to ERRW. No saturation is needed. On transfer → FBK.
  - FBK: `fbk_rdy`=1. Latch `fbk_dat` → DLT.
  - DLT: `dlt_stb`=1, `dlt_dat`=latched feedback. On transfer → IDLE.
- `en` = latched train. It updates on `inp` acceptance and is held stable from ARG through DLT.
- `train` is ignored outside IDLE. `tgt_stb` is ignored outside TGT.
- Reset values: state IDLE; all `stb` and `rdy` 0 (`inp_rdy` becomes 1 in the first cycle after reset release); `en` 0; all `*_dat` outputs 0; internal latches 0.
- Reset mid-operation (any state) aborts the sample. Every `stb`/`rdy` drops immediately (asynchronously). No partial transfer is completed afterwards. The next sample starts from IDLE.

## Timing

- Each state's `stb`/`rdy` asserts in the cycle after the state is entered. The state exits at the posedge of its transfer.
- One state per handshake. The minimum dwell is one cycle with a zero-wait partner.
- Forward-only sample, zero-wait partners: `inp` accepted at cycle 0, `arg` transfer at 1, `res` at 2, `out` at 3, `inp_rdy` high again at 4. The sustained rate is 1 sample per 4 cycles.
- Training sample, zero-wait partners: `out` at 3, `tgt` at 4, `err` at 5, `fbk` at 6, `dlt` at 7, IDLE at 8. The sustained rate is 1 sample per 8 cycles.
- Backpressure stalls only the current state. There is no buffering beyond one latched value per channel.
- `res_stb` or `fbk_stb` arriving early (before RES/FBK) is held off by `rdy`=0. It is never lost, as the unit holds it.

## Test plan

- Reset: assert `rst_n`=0 mid-cycle → all `stb`/`rdy`/`en`/`dat` outputs 0 asynchronously. After release, `inp_rdy`=1 on the next cycle.
- Forward: `train`=0, `inp_dat`=0, unit returns `res`=8'hff → `arg_dat`=0, `en`=0, `out_dat`=8'hff. No `tgt`/`err`/`dlt` activity. `inp_rdy` returns 4 cycles after acceptance.
- Train, positive error: `train`=1, `inp_dat`=16'hffff, `res`=8'h00, `tgt`=8'hff → `en`=1 from ARG, `err_dat`=16'h00ff. `fbk`=16'hffff → `dlt_dat`=16'hffff. Completes in 8 cycles.
- Train, negative error: `res`=8'hff, `tgt`=8'h00 → `err_dat`=16'hff01 (−255). Equal values 8'h80/8'h80 → `err_dat`=0.
- Backpressure: hold `out_rdy`=0 for 5 cycles, then `dlt_rdy`=0 for 3 cycles → `out_dat`/`dlt_dat` stay stable with `stb` high. The sample completes 8 cycles late with no duplicate transfers.
- Reset during ERR with `err_stb`=1 → `err_stb` drops immediately. The next forward sample (`inp`=0, `res`=8'hff) produces `out_dat`=8'hff and `en`=0.
